spinvaders_input_cond: RTL

SPINVADERS_INPUT_COND -- requirements
Module: spinvaders_input_cond

---
 rtl/spinvaders_input_cond.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spinvaders_input_cond.sv
// Button conditioning for the invaders game: synchronise, debounce, divide the game clock, hold fire.
// Optional macro SPINVADERS_AUTOFIRE_EN adds repeat fire every 8 game ticks while fire is held.
module spinvaders_input_cond #(
    parameter int unsigned DEBOUNCE_CNT = 500000,
    parameter int unsigned TICK_HALF    = 1250000
) (
    input  logic Clk,
    input  logic reset,
    input  logic BtnL,
    input  logic BtnR,
    input  logic BtnC,
    output logic game_clk,
    output logic L,
    output logic R,
    output logic shoot
);

    typedef enum logic [1:0] {IDLE, WAIT_HI, HIGH, WAIT_LO} db_state_t;

    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CNT - 1);
    localparam logic [23:0] TICK_LAST = 24'(TICK_HALF - 1);

    logic [2:0]  btn_raw;
    logic [2:0]  sync1_q, sync2_q;
    db_state_t   db_q     [3];
    logic [19:0] db_cnt_q [3];
    logic [2:0]  deb;

    logic [23:0] tick_cnt_q;
    logic        gclk_q, rise_q, tick;
    logic        l_q, r_q, fire_prev_q;
    logic        shoot_q, shoot_d, fire_set, auto_wrap;

    assign btn_raw = {BtnC, BtnR, BtnL};

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count runs only in the WAIT states; DEBOUNCE_CNT stable samples there commit the new level.
    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (reset) begin
                db_q[i]     <= IDLE;
                db_cnt_q[i] <= '0;
            end else begin
                case (db_q[i])
                    IDLE: begin
                        if (sync2_q[i]) begin
                            db_q[i]     <= WAIT_HI;
                            db_cnt_q[i] <= '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!sync2_q[i]) begin
                            db_q[i]     <= IDLE;
                            db_cnt_q[i] <= '0;
                        end else if (db_cnt_q[i] == DB_LAST) begin
                            db_q[i]     <= HIGH;
                            db_cnt_q[i] <= '0;
                        end else begin
                            db_cnt_q[i] <= db_cnt_q[i] + 20'd1;
                        end
                    end
                    HIGH: begin
                        if (!sync2_q[i]) begin
                            db_q[i]     <= WAIT_LO;
                            db_cnt_q[i] <= '0;
                        end
                    end
                    WAIT_LO: begin
                        if (sync2_q[i]) begin
                            db_q[i]     <= HIGH;
                            db_cnt_q[i] <= '0;
                        end else if (db_cnt_q[i] == DB_LAST) begin
                            db_q[i]     <= IDLE;
                            db_cnt_q[i] <= '0;
                        end else begin
                            db_cnt_q[i] <= db_cnt_q[i] + 20'd1;
                        end
                    end
                    default: begin
                        db_q[i]     <= IDLE;
                        db_cnt_q[i] <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        deb = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            deb[i] = (db_q[i] == HIGH) || (db_q[i] == WAIT_LO);
        end
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    // L/R only load on the falling toggle so the game never sees them change near its rising edge.
    always_ff @(posedge Clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            gclk_q      <= 1'b0;
            rise_q      <= 1'b0;
            l_q         <= 1'b0;
            r_q         <= 1'b0;
            fire_prev_q <= 1'b0;
            shoot_q     <= 1'b0;
        end else begin
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + 24'd1;
            gclk_q      <= tick ? ~gclk_q : gclk_q;
            rise_q      <= tick & ~gclk_q;
            fire_prev_q <= deb[2];
            shoot_q     <= shoot_d;
            if (tick && gclk_q) begin
                l_q <= deb[0];
                r_q <= deb[1];
            end
        end
    end

`ifdef SPINVADERS_AUTOFIRE_EN
    logic [2:0] af_cnt_q;

    // Advancing on the cycle after the rise lets the wrap's set collide with that rise's clear and win.
    always_ff @(posedge Clk) begin
        if (reset || !deb[2]) begin
            af_cnt_q <= '0;
        end else if (rise_q) begin
            af_cnt_q <= af_cnt_q + 3'd1;
        end
    end

    assign auto_wrap = rise_q & deb[2] & (af_cnt_q == 3'd7);
`else
    assign auto_wrap = 1'b0;
`endif

    assign fire_set = (deb[2] & ~fire_prev_q) | auto_wrap;

    always_comb begin
        shoot_d = shoot_q;
        if (rise_q) begin
            shoot_d = 1'b0;
        end
        if (fire_set) begin
            shoot_d = 1'b1;
        end
    end

    assign game_clk = gclk_q;
    assign L        = l_q;
    assign R        = r_q;
    assign shoot    = shoot_q;

endmodule
